// File: rtl/bcd2bin_reverse_dabble_if.sv
// rtl/bcd2bin_reverse_dabble_if.sv - start/busy/done handshake bundle for the BCD-to-binary converter
//
// Purpose: groups the request and result signals of bcd2bin_reverse_dabble.
// Signals:
//   start   requester -> converter  request, only honoured while the converter is idle
//   bcd_in  requester -> converter  20-bit packed BCD, digit k at [4k+3:4k], k=0 is units
//   busy    converter -> requester  conversion in progress
//   done    converter -> requester  one-cycle pulse, results valid from this cycle on
//   bin_out converter -> requester  binary result, N_BITS wide, held until next done
//   ovf     converter -> requester  result did not fit in N_BITS
//   err     converter -> requester  an input digit was greater than 9
// Modports: master = requester side, slave = converter side.

interface bcd2bin_reverse_dabble_if #(
  parameter int N_BITS = 16
);
  logic              start;
  logic [19:0]       bcd_in;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] bin_out;
  logic              ovf;
  logic              err;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  bin_out,
    input  ovf,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output bin_out,
    output ovf,
    output err
  );
endinterface

// File: rtl/bcd2bin_reverse_dabble.sv
// rtl/bcd2bin_reverse_dabble.sv - iterative reverse double-dabble BCD-to-binary converter
//
// Purpose: converts a 5-digit packed BCD operand to unsigned binary, one shift
// per clock, with fixed latency (21 clocks for valid input, 2 clocks when a
// digit is invalid).
// Ports:
//   clk  input   rising-edge clock
//   rst  input   synchronous reset, active-high, overrides start
//   bus  slave   start/bcd_in request, busy/done/bin_out/ovf/err response
// Parameter:
//   N_BITS  binary output width, 1..20; widths of 17 and above never overflow.

module bcd2bin_reverse_dabble #(
  parameter int N_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd2bin_reverse_dabble_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    ERR_WAIT = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t            state_q;
  logic [19:0]       bcd_q;
  logic [19:0]       bin_q;
  logic [4:0]        cnt_q;
  logic              err_pend_q;
  logic              busy_q;
  logic              done_q;
  logic [N_BITS-1:0] bin_out_q;
  logic              ovf_q;
  logic              err_q;

  // next values of the shift pair for one dabble step
  logic [19:0] bcd_shift;
  logic [19:0] bcd_d;
  logic [19:0] bin_d;
  logic        ovf_d;

  // A digit that reached 8 or more after the right shift held 10 or more
  // before it; removing 3 undoes the extra weight the shift brought down.
  function automatic logic [3:0] dabble_fix(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  function automatic logic has_bad_digit(input logic [19:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (v[4*k +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  always_comb begin
    bcd_shift = {1'b0, bcd_q[19:1]};
    bin_d     = {bcd_q[0], bin_q[19:1]};
    bcd_d     = '0;
    for (int k = 0; k < 5; k++) begin
      bcd_d[4*k +: 4] = dabble_fix(bcd_shift[4*k +: 4]);
    end
    // bits above the output width; the shift yields zero when N_BITS is 20
    ovf_d = |(bin_q >> N_BITS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bin_out_q  <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            bcd_q  <= bus.bcd_in;
            bin_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (has_bad_digit(bus.bcd_in)) begin
              err_pend_q <= 1'b1;
              // invalid operands still take a fixed two-cycle path
              state_q    <= ERR_WAIT;
            end else begin
              err_pend_q <= 1'b0;
              state_q    <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd19) begin
            state_q <= FINISH;
          end
        end
        ERR_WAIT: begin
          state_q <= FINISH;
        end
        FINISH: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          if (err_pend_q) begin
            bin_out_q <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            bin_out_q <= bin_q[N_BITS-1:0];
            ovf_q     <= ovf_d;
            err_q     <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bin_out = bin_out_q;
  assign bus.ovf     = ovf_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd2bin_reverse_dabble.sv
// tb/tb_bcd2bin_reverse_dabble.sv - self-checking bench for bcd2bin_reverse_dabble (N_BITS 16 and 20)

module tb_bcd2bin_reverse_dabble;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] bcd_in;

  int n_checks;
  int n_fail;

  bcd2bin_reverse_dabble_if #(.N_BITS(16)) u_if16 ();
  bcd2bin_reverse_dabble_if #(.N_BITS(20)) u_if20 ();

  assign u_if16.start  = start;
  assign u_if16.bcd_in = bcd_in;
  assign u_if20.start  = start;
  assign u_if20.bcd_in = bcd_in;

  bcd2bin_reverse_dabble #(.N_BITS(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (u_if16.slave)
  );

  bcd2bin_reverse_dabble #(.N_BITS(20)) u_dut20 (
    .clk (clk),
    .rst (rst),
    .bus (u_if20.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal value from the digits, plain arithmetic.
  function automatic void model(input logic [19:0] v, output int val, output bit bad);
    val = 0;
    bad = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      int d;
      d = int'(v[4*k +: 4]);
      if (d > 9) bad = 1'b1;
      val = val * 10 + d;
    end
  endfunction

  // Issues one request and waits (bounded) for the 16-bit unit's done.
  // lat = clocks from the accepting edge to done, -1 on timeout.
  task automatic do_conv(input logic [19:0] v, output int lat, output logic busy1,
                         output bit stable, output bit done20);
    logic [15:0] h_bin;
    logic        h_ovf;
    logic        h_err;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 20'($urandom);
    busy1  = u_if16.busy;
    h_bin  = u_if16.bin_out;
    h_ovf  = u_if16.ovf;
    h_err  = u_if16.err;
    stable = 1'b1;
    lat    = -1;
    done20 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (u_if16.done) begin
        lat    = i;
        done20 = u_if20.done;
        break;
      end
      if (u_if16.bin_out !== h_bin || u_if16.ovf !== h_ovf || u_if16.err !== h_err)
        stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({u_if16.busy, u_if16.done, u_if16.ovf, u_if16.err} !== 4'b0 || u_if16.bin_out !== 16'h0) begin
      n_fail++;
      $display("FAIL reset16: busy=%b done=%b ovf=%b err=%b bin=%h, required all zero",
               u_if16.busy, u_if16.done, u_if16.ovf, u_if16.err, u_if16.bin_out);
    end
    n_checks++;
    if ({u_if20.busy, u_if20.done, u_if20.ovf, u_if20.err} !== 4'b0 || u_if20.bin_out !== 20'h0) begin
      n_fail++;
      $display("FAIL reset20: busy=%b done=%b ovf=%b err=%b bin=%h, required all zero",
               u_if20.busy, u_if20.done, u_if20.ovf, u_if20.err, u_if20.bin_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [19:0] bcd;
    logic [15:0] bin16;
    logic        ovf16;
    logic [19:0] bin20;
    logic        err;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[9];
    int   lat;
    logic busy1;
    bit   stable;
    bit   d20;
    tbl[0] = '{20'h12345, 16'h3039, 1'b0, 20'h03039, 1'b0, 21};
    tbl[1] = '{20'h00000, 16'h0000, 1'b0, 20'h00000, 1'b0, 21};
    tbl[2] = '{20'h65535, 16'hFFFF, 1'b0, 20'h0FFFF, 1'b0, 21};
    tbl[3] = '{20'h00009, 16'h0009, 1'b0, 20'h00009, 1'b0, 21};
    tbl[4] = '{20'h65536, 16'h0000, 1'b1, 20'h10000, 1'b0, 21};
    tbl[5] = '{20'h99999, 16'h869F, 1'b1, 20'h1869F, 1'b0, 21};
    tbl[6] = '{20'h1A000, 16'h0000, 1'b0, 20'h00000, 1'b1, 2};
    tbl[7] = '{20'h00042, 16'h002A, 1'b0, 20'h0002A, 1'b0, 21};
    tbl[8] = '{20'h00010, 16'h000A, 1'b0, 20'h0000A, 1'b0, 21};
    foreach (tbl[i]) begin
      do_conv(tbl[i].bcd, lat, busy1, stable, d20);
      n_checks++;
      if (lat !== tbl[i].lat || busy1 !== 1'b1) begin
        n_fail++;
        $display("FAIL dir_latency bcd=%h: lat=%0d busy_after_start=%b, required lat=%0d busy=1",
                 tbl[i].bcd, lat, busy1, tbl[i].lat);
      end
      n_checks++;
      if (u_if16.bin_out !== tbl[i].bin16 || u_if16.ovf !== tbl[i].ovf16 ||
          u_if16.err !== tbl[i].err || u_if16.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_result16 bcd=%h: bin=%h ovf=%b err=%b busy=%b, required bin=%h ovf=%b err=%b busy=0",
                 tbl[i].bcd, u_if16.bin_out, u_if16.ovf, u_if16.err, u_if16.busy,
                 tbl[i].bin16, tbl[i].ovf16, tbl[i].err);
      end
      n_checks++;
      if (d20 !== 1'b1 || u_if20.bin_out !== tbl[i].bin20 || u_if20.ovf !== 1'b0 ||
          u_if20.err !== tbl[i].err) begin
        n_fail++;
        $display("FAIL dir_result20 bcd=%h: done=%b bin=%h ovf=%b err=%b, required done=1 bin=%h ovf=0 err=%b",
                 tbl[i].bcd, d20, u_if20.bin_out, u_if20.ovf, u_if20.err, tbl[i].bin20, tbl[i].err);
      end
      n_checks++;
      if (stable !== 1'b1) begin
        n_fail++;
        $display("FAIL dir_hold bcd=%h: outputs changed before done (stable=%b), required 1",
                 tbl[i].bcd, stable);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (u_if16.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: done=%b one cycle after pulse, required 0", u_if16.done);
    end
  endtask

  task automatic test_random();
    int          lat;
    logic        busy1;
    bit          stable;
    bit          d20;
    logic [19:0] v;
    int          val;
    bit          bad;
    logic [31:0] uval;
    logic [15:0] e_bin;
    logic        e_ovf;
    int          e_lat;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 15) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
        else                            v[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      model(v, val, bad);
      uval  = 32'(val);
      e_bin = bad ? 16'h0 : uval[15:0];
      e_ovf = !bad && (val > 65535);
      e_lat = bad ? 2 : 21;
      do_conv(v, lat, busy1, stable, d20);
      n_checks++;
      if (lat !== e_lat || busy1 !== 1'b1 || stable !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_timing bcd=%h: lat=%0d busy=%b stable=%b, required lat=%0d busy=1 stable=1",
                 v, lat, busy1, stable, e_lat);
      end
      n_checks++;
      if (u_if16.bin_out !== e_bin || u_if16.ovf !== e_ovf || u_if16.err !== bad) begin
        n_fail++;
        $display("FAIL rnd_result16 bcd=%h: bin=%h ovf=%b err=%b, required bin=%h ovf=%b err=%b",
                 v, u_if16.bin_out, u_if16.ovf, u_if16.err, e_bin, e_ovf, bad);
      end
      n_checks++;
      if (d20 !== 1'b1 || u_if20.bin_out !== (bad ? 20'h0 : uval[19:0]) || u_if20.ovf !== 1'b0 ||
          u_if20.err !== bad) begin
        n_fail++;
        $display("FAIL rnd_result20 bcd=%h: done=%b bin=%h ovf=%b err=%b, required done=1 bin=%h ovf=0 err=%b",
                 v, d20, u_if20.bin_out, u_if20.ovf, u_if20.err, bad ? 20'h0 : uval[19:0], bad);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int          n_done;
    int          first;
    logic [15:0] r_bin;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 20'h12345;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n_done = 0;
    first  = -1;
    r_bin  = '0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 5) begin
        start  = 1'b1;
        bcd_in = 20'h00001;
      end
      @(posedge clk);
      #1;
      if (i == 5) start = 1'b0;
      if (u_if16.done) begin
        n_done++;
        if (first < 0) begin
          first = i;
          r_bin = u_if16.bin_out;
        end
      end
    end
    n_checks++;
    if (n_done !== 1 || first !== 21 || r_bin !== 16'h3039) begin
      n_fail++;
      $display("FAIL ignore_busy: dones=%0d first=%0d bin=%h, required dones=1 first=21 bin=3039",
               n_done, first, r_bin);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic busy1;
    bit   stable;
    bit   d20;
    do_conv(20'h12345, lat, busy1, stable, d20);
    n_checks++;
    if (lat !== 21 || u_if16.bin_out !== 16'h3039) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d bin=%h, required lat=21 bin=3039", lat, u_if16.bin_out);
    end
    // issued from inside the done cycle
    do_conv(20'h00007, lat, busy1, stable, d20);
    n_checks++;
    if (lat !== 21 || busy1 !== 1'b1 || u_if16.bin_out !== 16'h0007 || u_if16.err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d busy=%b bin=%h err=%b, required lat=21 busy=1 bin=0007 err=0",
               lat, busy1, u_if16.bin_out, u_if16.err);
    end
  endtask

  task automatic test_reset_mid();
    int   n_done;
    int   lat;
    logic busy1;
    bit   stable;
    bit   d20;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 20'h54321;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({u_if16.busy, u_if16.done, u_if16.ovf, u_if16.err} !== 4'b0 || u_if16.bin_out !== 16'h0 ||
        u_if20.busy !== 1'b0 || u_if20.bin_out !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b ovf=%b err=%b bin=%h busy20=%b bin20=%h, required all zero",
               u_if16.busy, u_if16.done, u_if16.ovf, u_if16.err, u_if16.bin_out,
               u_if20.busy, u_if20.bin_out);
    end
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (u_if16.done || u_if20.done || u_if16.busy) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: %0d cycles with done/busy after reset, required 0", n_done);
    end
    do_conv(20'h00100, lat, busy1, stable, d20);
    n_checks++;
    if (lat !== 21 || u_if16.bin_out !== 16'h0064 || u_if16.ovf !== 1'b0 || u_if16.err !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: lat=%0d bin=%h ovf=%b err=%b, required lat=21 bin=0064 ovf=0 err=0",
               lat, u_if16.bin_out, u_if16.ovf, u_if16.err);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
